// File: rtl/fetch_ctrl.sv
// fetch_ctrl: issues tagged line fetches, tracks credits/in-flight requests, writes in-order responses to the buffer.
module fetch_ctrl #(
  parameter int XLEN = 32,
  parameter int IB_DEPTH = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W = 3,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int CW = $clog2(IB_DEPTH) + 1,
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic [XLEN-1:0]  branch_target,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic [TAG_W-1:0] mem_req_tag,
  input  logic             mem_rsp_valid,
  input  logic [TAG_W-1:0] mem_rsp_tag,
  input  logic [63:0]      mem_rsp_data,
  output logic             ib_wr_valid,
  output logic [XLEN-1:0]  ib_wr_pc,
  output logic [63:0]      ib_wr_data,
  output logic [1:0]       ib_wr_slot_valid,
  input  logic             ib_pop,
  output logic [CW-1:0]    credits,
  output logic [OW-1:0]    outstanding,
  output logic             tag_err
);
  typedef enum logic {FETCH, REDIRECT} state_t;
  localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(7);
  state_t state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, rsp_pc_q, rsp_pc_d, wr_pc_q, wr_pc_d;
  logic [TAG_W-1:0] tag_q, tag_d, exp_tag_q, exp_tag_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [CW:0] csum;
  logic [OW-1:0] outstanding_q, outstanding_d, stale_q, stale_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic [1:0] wr_slot_q, wr_slot_d;
  logic tag_err_q, tag_err_d, first_q, first_d, wr_valid_q, wr_valid_d;
  logic issue, pop, live;
  always_comb begin
    mem_req_valid = !reset && !squash && state_q == FETCH && credits_q != '0 &&
                    outstanding_q < OW'(MAX_OUTSTANDING);
    issue = mem_req_valid && mem_req_ready;
    pop = ib_pop && !squash;
    // a response is forwarded only if it belongs to the current fetch stream
    live = mem_rsp_valid && stale_q == '0 && !squash;
    outstanding_d = outstanding_q + OW'(issue) - OW'(mem_rsp_valid);
    csum = {1'b0, credits_q} + (CW+1)'(pop) - (CW+1)'(issue);
    credits_d = squash ? CW'(IB_DEPTH) :
                csum > (CW+1)'(IB_DEPTH) ? CW'(IB_DEPTH) : csum[CW-1:0];
    stale_d = squash ? outstanding_d : stale_q - OW'(mem_rsp_valid && stale_q != '0);
    addr_d = squash ? branch_target & LINE_MASK : issue ? addr_q + XLEN'(8) : addr_q;
    tag_d = issue ? tag_q + TAG_W'(1) : tag_q;
    exp_tag_d = mem_rsp_valid ? exp_tag_q + TAG_W'(1) : exp_tag_q;
    tag_err_d = tag_err_q || (mem_rsp_valid && mem_rsp_tag != exp_tag_q);
    rsp_pc_d = squash ? branch_target & LINE_MASK : live ? rsp_pc_q + XLEN'(8) : rsp_pc_q;
    first_d = squash ? branch_target[2] : live ? 1'b0 : first_q;
    wr_valid_d = live;
    wr_pc_d = live ? rsp_pc_q : wr_pc_q;
    wr_data_d = live ? mem_rsp_data : wr_data_q;
    wr_slot_d = live ? (first_q ? 2'b10 : 2'b11) : 2'b00;
    state_d = squash ? REDIRECT : FETCH;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      addr_q <= RESET_PC & LINE_MASK;
      rsp_pc_q <= RESET_PC & LINE_MASK;
      tag_q <= '0;
      exp_tag_q <= '0;
      credits_q <= CW'(IB_DEPTH);
      outstanding_q <= '0;
      stale_q <= '0;
      tag_err_q <= 1'b0;
      first_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_pc_q <= '0;
      wr_data_q <= '0;
      wr_slot_q <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rsp_pc_q <= rsp_pc_d;
      tag_q <= tag_d;
      exp_tag_q <= exp_tag_d;
      credits_q <= credits_d;
      outstanding_q <= outstanding_d;
      stale_q <= stale_d;
      tag_err_q <= tag_err_d;
      first_q <= first_d;
      wr_valid_q <= wr_valid_d;
      wr_pc_q <= wr_pc_d;
      wr_data_q <= wr_data_d;
      wr_slot_q <= wr_slot_d;
    end
  end
  assign mem_req_addr = addr_q;
  assign mem_req_tag = tag_q;
  assign ib_wr_valid = wr_valid_q;
  assign ib_wr_pc = wr_pc_q;
  assign ib_wr_data = wr_data_q;
  assign ib_wr_slot_valid = wr_slot_q;
  assign credits = credits_q;
  assign outstanding = outstanding_q;
  assign tag_err = tag_err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: random traffic against a queue-based reference model of the fetch stream.
module tb_fetch_ctrl;
  logic clock = 0, reset = 1, squash = 0, mem_req_ready = 0, mem_rsp_valid = 0, ib_pop = 0;
  logic [31:0] branch_target = 0, mem_req_addr, ib_wr_pc;
  logic [2:0] mem_req_tag, mem_rsp_tag = 0;
  logic [63:0] mem_rsp_data = 0, ib_wr_data;
  logic mem_req_valid, ib_wr_valid, tag_err;
  logic [1:0] ib_wr_slot_valid;
  logic [4:0] credits;
  logic [2:0] outstanding;
  fetch_ctrl dut (
    .clock(clock), .reset(reset), .squash(squash), .branch_target(branch_target),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_data(mem_rsp_data), .ib_wr_valid(ib_wr_valid), .ib_wr_pc(ib_wr_pc),
    .ib_wr_data(ib_wr_data), .ib_wr_slot_valid(ib_wr_slot_valid), .ib_pop(ib_pop),
    .credits(credits), .outstanding(outstanding), .tag_err(tag_err)
  );
  always #5 clock = ~clock;
  typedef struct {logic [31:0] addr; bit live;} req_t;
  typedef struct {logic [2:0] tag; int due;} mem_t;
  req_t inflight[$];
  mem_t mq[$];
  int total = 0, bad = 0, cyc = 0, m_credits, m_occ;
  logic [31:0] m_addr, m_pc;
  logic [2:0] m_tag, m_exp;
  logic [63:0] m_data;
  logic [1:0] m_slot;
  bit m_err, m_redirect, m_first, m_wv, corrupt;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1; squash = 0; mem_req_ready = 0; mem_rsp_valid = 0; ib_pop = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_tag", mem_req_tag, 0);
    chk("rst_wr_valid", ib_wr_valid, 0);
    chk("rst_wr_slot", ib_wr_slot_valid, 0);
    chk("rst_wr_pc", ib_wr_pc, 0);
    chk("rst_wr_data", ib_wr_data, 0);
    chk("rst_credits", credits, 16);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_tag_err", tag_err, 0);
    inflight.delete(); mq.delete();
    m_credits = 16; m_occ = 0; m_addr = 0; m_tag = 0; m_exp = 0;
    m_err = 0; m_redirect = 0; m_first = 0; m_wv = 0;
    reset = 0;
  endtask
  task automatic run(int n, int p_ready, int p_rsp, int lat, int p_pop, int p_sq, bit no_rsp);
    bit exp_valid, issue;
    req_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cyc++;
      mem_req_ready = $urandom_range(99) < p_ready;
      squash = $urandom_range(99) < p_sq;
      branch_target = $urandom_range(3) == 0 ? $urandom : 32'($urandom_range(4095));
      ib_pop = m_occ > 0 && $urandom_range(99) < p_pop;
      mem_rsp_valid = 0;
      if (!no_rsp && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < p_rsp) begin
        mem_rsp_valid = 1;
        mem_rsp_tag = mq[0].tag ^ {2'b0, corrupt};
        corrupt = 0;
        mem_rsp_data = {$urandom, $urandom};
        void'(mq.pop_front());
      end
      #1;
      exp_valid = !m_redirect && m_credits > 0 && inflight.size() < 4 && !squash;
      issue = exp_valid && mem_req_ready;
      chk("req_valid", mem_req_valid, exp_valid);
      if (exp_valid) begin
        chk("req_addr", mem_req_addr, m_addr);
        chk("req_tag", mem_req_tag, m_tag);
      end
      chk("credits", credits, m_credits);
      chk("outstanding", outstanding, inflight.size());
      chk("tag_err", tag_err, m_err);
      chk("wr_valid", ib_wr_valid, m_wv);
      chk("wr_slot", ib_wr_slot_valid, m_wv ? m_slot : 2'b00);
      if (m_wv) begin
        chk("wr_pc", ib_wr_pc, m_pc);
        chk("wr_data", ib_wr_data, m_data);
      end
      m_wv = 0;
      if (mem_rsp_valid) begin
        e = inflight.pop_front();
        if (mem_rsp_tag != m_exp) m_err = 1;
        m_exp++;
        if (e.live && !squash) begin
          m_wv = 1; m_pc = e.addr; m_data = mem_rsp_data;
          m_slot = m_first ? 2'b10 : 2'b11;
          m_first = 0;
          m_occ++;
        end
      end
      if (issue) begin
        inflight.push_back('{m_addr, 1'b1});
        mq.push_back('{m_tag, cyc + lat});
        m_addr += 8; m_tag++; m_credits--;
      end
      if (ib_pop && !squash) begin
        m_occ--;
        if (m_credits < 16) m_credits++;
      end
      m_redirect = squash;
      if (squash) begin
        foreach (inflight[k]) inflight[k].live = 0;
        m_credits = 16; m_occ = 0; m_addr = branch_target & ~32'd7;
        m_first = branch_target[2];
      end
    end
  endtask
  initial begin
    corrupt = 0;
    do_reset();
    run(60, 100, 100, 2, 100, 0, 0);
    run(80, 100, 100, 1, 0, 0, 0);
    run(40, 100, 100, 1, 30, 0, 0);
    do_reset();
    run(30, 100, 0, 1, 0, 0, 1);
    run(30, 100, 100, 1, 60, 0, 0);
    run(1500, 70, 60, 1, 50, 6, 0);
    run(1500, 80, 80, 3, 40, 3, 0);
    corrupt = 1;
    run(100, 80, 80, 1, 50, 2, 0);
    chk("tag_err_sticky", tag_err, 1);
    do_reset();
    run(1500, 90, 50, 2, 60, 10, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch into the instruction buffer.
- Generates 8-byte-aligned line addresses and issues tagged requests to instruction memory, one line (two instructions) per request.
- Reserves buffer space with credits and forwards in-order responses as two-slot buffer writes.
- On squash, redirects to the branch target and discards responses still in flight.

Parameters:
- XLEN, 32, address width.
- IB_DEPTH, 16, instruction buffer line entries; initial and post-squash credit count.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests, stale ones included.
- TAG_W, 3, request tag width; tags are sequence numbers modulo 2^TAG_W; requires 2^TAG_W > MAX_OUTSTANDING.
- RESET_PC, 0, first fetch address.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  redirect fetch and flush the buffer
- branch_target  in  XLEN  redirect PC
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  line address, bits [2:0] = 0
- mem_req_tag  out  TAG_W  request sequence tag
- mem_rsp_valid  in  1  response valid; responses return in issue order
- mem_rsp_tag  in  TAG_W  tag of response
- mem_rsp_data  in  64  {inst1, inst0}
- ib_wr_valid  out  1  write one line into buffer
- ib_wr_pc  out  XLEN  line base PC
- ib_wr_data  out  64  line data
- ib_wr_slot_valid  out  2  per-instruction valid
- ib_pop  in  1  buffer freed one line entry
- credits  out  $clog2(IB_DEPTH)+1  free, unreserved buffer entries
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  in-flight requests
- tag_err  out  1  sticky: response tag mismatch

Behaviour:
- Reset values:
  - mem_req_valid = 0, mem_req_addr = RESET_PC aligned, mem_req_tag = 0.
  - ib_wr_valid = 0, ib_wr_slot_valid = 0, ib_wr_pc = 0, ib_wr_data = 0.
  - credits = IB_DEPTH, outstanding = 0, tag_err = 0.
  - Stale count = 0, expected tag = 0, state = FETCH.
- States:
  - FETCH: mem_req_valid = (credits > 0) && (outstanding < MAX_OUTSTANDING). When valid, it is held with addr/tag stable until mem_req_ready.
  - REDIRECT: one cycle following squash; no request issued; enters FETCH.
- Issue handshake (valid && ready):
  - outstanding += 1, credits -= 1, addr += 8, tag += 1.
  - The next request may be presented in the following cycle.
- Squash, which has priority over everything:
  - Any unaccepted request is withdrawn the same cycle; the memory side tolerates this.
  - addr <= branch_target & ~7.
  - Stale count <= outstanding after this cycle's handshake/response.
  - credits <= IB_DEPTH.
  - ib_pop in this cycle is ignored.
  - state <= REDIRECT.
  - A first-line flag is set to branch_target[2].
- Responses:
  - While stale count > 0, each response is dropped: stale count -= 1, outstanding -= 1, no buffer write, no credit change.
  - Otherwise: outstanding -= 1, and one cycle later ib_wr_valid = 1 with the response data and its line PC.
  - ib_wr_slot_valid = 2'b10 if the first-line flag is set (flag then clears), else 2'b11.
  - Responses are never back-pressured.
- Tag check: mem_rsp_tag != expected tag sets tag_err, which is sticky until reset. The expected tag increments on every response, stale included.
- Counter arithmetic: issue, response and ib_pop in the same cycle net out.
  - credits = credits - issue + pop.
  - outstanding = outstanding + issue - rsp.
  - credits saturates at IB_DEPTH; a pop at IB_DEPTH is ignored.
- Addresses wrap modulo 2^XLEN. Tags wrap modulo 2^TAG_W.
- Reset mid-operation: all state clears; any in-flight responses are the memory's responsibility and are not tracked after reset.

Test Plan:
1. After reset, mem_req_ready held 1 and responses 2 cycles after each issue → addrs 0x0, 0x8, 0x10, …; outstanding peaks at 2; each ib_wr_valid carries the matching pc with slot_valid = 2'b11.
2. ib_pop held 0, memory answers immediately → exactly 16 requests issue, then mem_req_valid = 0 with credits = 0; a single ib_pop → exactly one more request at 0x80.
3. Memory never responds → 4 requests (0x0–0x18) issue, then mem_req_valid = 0 with outstanding = 4; one response → the fifth request at 0x20 issues.
4. 3 outstanding, then squash with branch_target = 0x104 → next 3 responses produce no ib_wr_valid; first request after REDIRECT is addr 0x100; its write has slot_valid = 2'b10; the following line 0x108 has 2'b11; credits = 16 minus post-squash issues.
5. Same cycle: issue accept, response, and ib_pop with credits = 5 and outstanding = 2 → next cycle credits = 5, outstanding = 2.
6. Response arrives with tag 3 while expected tag is 2 → tag_err = 1 and stays 1 until reset; reset then clears it.
